// File: rtl/s2p_pkg.sv
// Shared definitions for the serial/parallel chain: state encoding and default frame width.
package s2p_pkg;

    localparam int unsigned S2P_WIDTH = 8;
    localparam int unsigned ST_W      = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_PARITY = 2'd2;

endpackage

// File: rtl/s2p_shift_in.sv
// WIDTH-bit left shift register: serial bit enters at bit 0, so the first bit ends up in the MSB.
module s2p_shift_in #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= {sr_q[WIDTH-2:0], d_i};
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/s2p_receiver.sv
// Serial-to-parallel receiver with one-entry holding register and sticky error flags.
// Optional odd-parity check enabled by defining S2P_PARITY_CHECK_EN.
module s2p_receiver
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH = S2P_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_start,
    input  logic             p_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

`ifdef S2P_PARITY_CHECK_EN
    localparam state_t ST_DATA_DONE = ST_PARITY;
`else
    localparam state_t ST_DATA_DONE = ST_IDLE;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, word_c, p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d, busy_q;
    logic             frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic             shift_en_c, last_bit_c, done_c, abort_c, ovr_set_c;
`ifdef S2P_PARITY_CHECK_EN
    logic             parity_err_q, parity_err_d, par_fail_c;
`endif

    assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
    assign shift_en_c = s_valid & (s_start | (state_q == ST_SHIFT));

    s2p_shift_in #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (shift_en_c),
        .d_i   (s_in),
        .q_o   (sr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // s_start with a strobe always (re)starts a frame, whatever the state.
    always_comb begin
        state_d = state_q;
        if (s_valid) begin
            if (s_start) begin
                state_d = ST_SHIFT;
            end else begin
                case (state_q)
                    ST_SHIFT:  if (last_bit_c) state_d = ST_DATA_DONE;
                    ST_PARITY: state_d = ST_IDLE;
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        abort_c   = 1'b0;
        done_c    = 1'b0;
        word_c    = sr_q;
        ovr_set_c = 1'b0;
        p_out_d   = p_out_q;
        p_valid_d = p_valid_q;
`ifdef S2P_PARITY_CHECK_EN
        par_fail_c = 1'b0;
`endif
        if (s_valid) begin
            if (s_start) begin
                cnt_d   = CNT_W'(1);
                abort_c = (state_q != ST_IDLE);
            end else if (state_q == ST_SHIFT) begin
                if (last_bit_c) begin
                    cnt_d = '0;
`ifndef S2P_PARITY_CHECK_EN
                    done_c = 1'b1;
                    word_c = {sr_q[WIDTH-2:0], s_in};
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`ifdef S2P_PARITY_CHECK_EN
            end else if (state_q == ST_PARITY) begin
                cnt_d = '0;
                if (^{sr_q, s_in}) begin
                    done_c = 1'b1;
                end else begin
                    par_fail_c = 1'b1;
                end
`endif
            end
        end

        // A transfer this cycle frees the slot for a word completing in the same cycle.
        if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
        if (done_c) begin
            if (!p_valid_q || p_ready) begin
                p_out_d   = word_c;
                p_valid_d = 1'b1;
            end else begin
                ovr_set_c = 1'b1;
            end
        end

        frame_err_d = abort_c | (frame_err_q & ~err_clr);
        overrun_d   = ovr_set_c | (overrun_q & ~err_clr);
`ifdef S2P_PARITY_CHECK_EN
        parity_err_d = par_fail_c | (parity_err_q & ~err_clr);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            p_out_q     <= '0;
            p_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            p_out_q     <= p_out_d;
            p_valid_q   <= p_valid_d;
            busy_q      <= (state_d != ST_IDLE);
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef S2P_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign p_out     = p_out_q;
    assign p_valid   = p_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
